// File: rtl/axi_ctr_pkg.sv
// Shared definitions for the multi-channel AXI4-Lite counter peripheral.
// Provides the AXI response encoding, register byte offsets within a
// channel window, CTRL bit positions and the write/read FSM state types.
package axi_ctr_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    // Byte offsets inside one 16-byte channel window
    localparam logic [3:0] CTRL_OFF  = 4'h0;
    localparam logic [3:0] VALUE_OFF = 4'h4;
    localparam logic [3:0] CMP_OFF   = 4'h8;
    localparam logic [3:0] STAT_OFF  = 4'hC;

    // CTRL bit positions
    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_WRAP   = 1;
    localparam int unsigned CTRL_DOWN   = 2;
    localparam int unsigned CTRL_IRQ_EN = 3;
    localparam int unsigned CTRL_BITS   = 4;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wfsm_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rfsm_t;

endpackage

// File: rtl/counter_channel.sv
// One counter channel: CTRL/VALUE/COMPARE/STATUS registers plus count and
// match logic.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   wr_en            register write strobe for this channel
//   wr_sel           register index (byte offset >> 2)
//   wr_data          write data
//   ctrl/value/cmp   current register contents
//   match            sticky match status
//   irq              match & irq_en
module counter_channel
    import axi_ctr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [1:0]            wr_sel,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [CTRL_BITS-1:0]  ctrl,
    output logic [DATA_WIDTH-1:0] value,
    output logic [DATA_WIDTH-1:0] cmp,
    output logic                  match,
    output logic                  irq
);

    localparam logic [1:0] SEL_CTRL  = CTRL_OFF[3:2];
    localparam logic [1:0] SEL_VALUE = VALUE_OFF[3:2];
    localparam logic [1:0] SEL_CMP   = CMP_OFF[3:2];
    localparam logic [1:0] SEL_STAT  = STAT_OFF[3:2];

    logic [CTRL_BITS-1:0]  ctrl_q,  ctrl_d;
    logic [DATA_WIDTH-1:0] value_q, value_d;
    logic [DATA_WIDTH-1:0] cmp_q,   cmp_d;
    logic                  match_q, match_d;
    logic                  hit;

    always_comb begin
        ctrl_d  = ctrl_q;
        value_d = value_q;
        cmp_d   = cmp_q;
        match_d = match_q;
        hit     = 1'b0;

        if (ctrl_q[CTRL_EN]) begin
            if (!ctrl_q[CTRL_DOWN]) begin
                if (value_q == cmp_q) begin
                    hit = 1'b1;
                    if (ctrl_q[CTRL_WRAP]) value_d = '0;
                    else                   ctrl_d[CTRL_EN] = 1'b0;
                end else begin
                    value_d = value_q + DATA_WIDTH'(1);
                end
            end else begin
                if (value_q == '0) begin
                    hit = 1'b1;
                    if (ctrl_q[CTRL_WRAP]) value_d = cmp_q;
                    else                   ctrl_d[CTRL_EN] = 1'b0;
                end else begin
                    value_d = value_q - DATA_WIDTH'(1);
                end
            end
        end

        // Software writes are applied after the count so they take priority
        // over the count result and the hardware en-clear.
        if (wr_en) begin
            case (wr_sel)
                SEL_CTRL:  ctrl_d  = wr_data[CTRL_BITS-1:0];
                SEL_VALUE: value_d = wr_data;
                SEL_CMP:   cmp_d   = wr_data;
                SEL_STAT:  if (wr_data[0]) match_d = 1'b0;
                default:   ;
            endcase
        end

        // A hardware match in the same cycle as a W1C keeps the flag set
        if (hit) match_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q  <= '0;
            value_q <= '0;
            cmp_q   <= '0;
            match_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            value_q <= value_d;
            cmp_q   <= cmp_d;
            match_q <= match_d;
        end
    end

    assign ctrl  = ctrl_q;
    assign value = value_q;
    assign cmp   = cmp_q;
    assign match = match_q;
    assign irq   = match_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: rtl/axi_multi_counter.sv
// AXI4-Lite slave exposing NUM_CH independent counters (channel c at c*0x10).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   s_axi_aw*/w*/b* write address, data and response channels
//   s_axi_ar*/r*    read address and data channels
//   irq             per-channel level interrupt
module axi_multi_counter
    import axi_ctr_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [NUM_CH-1:0]     irq
);

    localparam int unsigned CH_W = ADDR_WIDTH - 4;

    logic [CTRL_BITS-1:0]  ch_ctrl  [NUM_CH];
    logic [DATA_WIDTH-1:0] ch_value [NUM_CH];
    logic [DATA_WIDTH-1:0] ch_cmp   [NUM_CH];
    logic [NUM_CH-1:0]     ch_match;

    // Byte-lane bits are not decoded
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // ---------------- write path ----------------
    wfsm_t                 wstate_q, wstate_d;
    logic                  awready_q, awready_d;
    logic                  wready_q,  wready_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q,  w_held_d;
    logic [ADDR_WIDTH-1:2] awaddr_q,  awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic                  bvalid_q,  bvalid_d;
    resp_t                 bresp_q,   bresp_d;

    logic                  aw_hs, w_hs, wr_go, wr_ch_ok;
    logic [ADDR_WIDTH-1:2] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [CH_W-1:0]       wr_ch;

    // AW and W may arrive in either order; each beat is parked until its
    // partner shows up, and a beat arriving this cycle is used directly.
    assign aw_hs    = s_axi_awvalid & awready_q;
    assign w_hs     = s_axi_wvalid & wready_q;
    assign wr_addr  = aw_hs ? s_axi_awaddr[ADDR_WIDTH-1:2] : awaddr_q;
    assign wr_data  = w_hs ? s_axi_wdata : wdata_q;
    assign wr_ch    = wr_addr[ADDR_WIDTH-1:4];
    assign wr_ch_ok = 32'(wr_ch) < NUM_CH;

    always_comb begin
        wstate_d  = wstate_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = wr_addr;
        wdata_d   = wr_data;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wr_go     = 1'b0;

        case (wstate_q)
            W_IDLE: begin
                if ((aw_held_q | aw_hs) && (w_held_q | w_hs)) begin
                    wr_go     = 1'b1;
                    wstate_d  = W_RESP;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = wr_ch_ok ? RESP_OKAY : RESP_SLVERR;
                end else begin
                    aw_held_d = aw_held_q | aw_hs;
                    w_held_d  = w_held_q | w_hs;
                    awready_d = ~(aw_held_q | aw_hs);
                    wready_d  = ~(w_held_q | w_hs);
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    wstate_d  = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;

    // ---------------- channels ----------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        counter_channel #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_go && wr_ch_ok && (wr_ch == CH_W'(c))),
            .wr_sel  (wr_addr[3:2]),
            .wr_data (wr_data),
            .ctrl    (ch_ctrl[c]),
            .value   (ch_value[c]),
            .cmp     (ch_cmp[c]),
            .match   (ch_match[c]),
            .irq     (irq[c])
        );
    end

    // ---------------- read path ----------------
    rfsm_t                 rstate_q,  rstate_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q,  rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    resp_t                 rresp_q,   rresp_d;

    logic                  ar_hs, ar_ok;
    logic [CH_W-1:0]       ar_ch;
    logic [DATA_WIDTH-1:0] rd_word;

    assign ar_hs = s_axi_arvalid & arready_q;
    assign ar_ch = s_axi_araddr[ADDR_WIDTH-1:4];
    assign ar_ok = 32'(ar_ch) < NUM_CH;

    always_comb begin
        rd_word = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ar_ch == CH_W'(c)) begin
                case (s_axi_araddr[3:2])
                    CTRL_OFF[3:2]:  rd_word = DATA_WIDTH'(ch_ctrl[c]);
                    VALUE_OFF[3:2]: rd_word = ch_value[c];
                    CMP_OFF[3:2]:   rd_word = ch_cmp[c];
                    default:        rd_word = DATA_WIDTH'(ch_match[c]);
                endcase
            end
        end
    end

    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        case (rstate_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    rstate_d  = R_DATA;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = ar_ok ? rd_word : '0;
                    rresp_d   = ar_ok ? RESP_OKAY : RESP_SLVERR;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    rstate_d  = R_IDLE;
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_multi_counter.sv
module tb_axi_multi_counter;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DW     = 32;
    localparam int unsigned AW     = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] awaddr;
    logic          awvalid, awready;
    logic [DW-1:0] wdata;
    logic          wvalid, wready;
    logic [1:0]    bresp;
    logic          bvalid, bready;
    logic [AW-1:0] araddr;
    logic          arvalid, arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid, rready;
    logic [NUM_CH-1:0] irq;

    always #5 clk = ~clk;

    axi_multi_counter #(
        .NUM_CH     (NUM_CH),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .irq           (irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0]    m_ctrl  [NUM_CH];
    logic [DW-1:0] m_val   [NUM_CH];
    logic [DW-1:0] m_cmp   [NUM_CH];
    logic          m_match [NUM_CH];

    function automatic void model_reset();
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            m_ctrl[c] = '0; m_val[c] = '0; m_cmp[c] = '0; m_match[c] = 1'b0;
        end
    endfunction

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        int unsigned ch;
        ch = 32'(a[AW-1:4]);
        if (ch >= NUM_CH) return '0;
        case (a[3:2])
            2'd0:    return {28'b0, m_ctrl[ch]};
            2'd1:    return m_val[ch];
            2'd2:    return m_cmp[ch];
            default: return {31'b0, m_match[ch]};
        endcase
    endfunction

    function automatic logic [1:0] m_resp(input logic [AW-1:0] a);
        return (32'(a[AW-1:4]) < NUM_CH) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [NUM_CH-1:0] m_irq();
        logic [NUM_CH-1:0] v;
        for (int unsigned c = 0; c < NUM_CH; c++) v[c] = m_match[c] & m_ctrl[c][3];
        return v;
    endfunction

    // One clock of every channel, then an optional register write on top.
    function automatic void model_step(input logic do_wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic hit [NUM_CH];
        int unsigned wch;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            logic          down, at_end;
            logic [DW-1:0] restart;
            hit[c]  = 1'b0;
            down    = m_ctrl[c][2];
            at_end  = down ? (m_val[c] == 0) : (m_val[c] == m_cmp[c]);
            restart = down ? m_cmp[c] : 32'd0;
            if (m_ctrl[c][0]) begin
                if (!at_end)           m_val[c] = down ? m_val[c] - 32'd1 : m_val[c] + 32'd1;
                else if (m_ctrl[c][1]) m_val[c] = restart;
                else                   m_ctrl[c][0] = 1'b0;
                if (at_end) begin
                    hit[c]     = 1'b1;
                    m_match[c] = 1'b1;
                end
            end
        end
        wch = 32'(a[AW-1:4]);
        if (do_wr && wch < NUM_CH) begin
            case (a[3:2])
                2'd0:    m_ctrl[wch] = d[3:0];
                2'd1:    m_val[wch]  = d;
                2'd2:    m_cmp[wch]  = d;
                default: if (d[0]) m_match[wch] = hit[wch];
            endcase
        end
    endfunction

    // ---------------- clock stepping with handshake tracking ----------------
    logic          aw_got, w_got, wr_landed, ar_seen;
    logic [AW-1:0] got_addr;
    logic [DW-1:0] got_data;
    logic [DW-1:0] exp_rdata;
    logic [1:0]    exp_rresp;

    task automatic tick();
        logic aw_hs, w_hs, ar_hs, in_rst;
        aw_hs  = awvalid && awready;
        w_hs   = wvalid && wready;
        ar_hs  = arvalid && arready;
        in_rst = rst;
        if (ar_hs) begin
            exp_rdata = m_read(araddr);
            exp_rresp = m_resp(araddr);
        end
        @(posedge clk);
        if (in_rst) begin
            model_reset();
            aw_got = 1'b0;
            w_got  = 1'b0;
        end else begin
            if (aw_hs) begin aw_got = 1'b1; got_addr = awaddr; end
            if (w_hs)  begin w_got  = 1'b1; got_data = wdata;  end
            if (aw_got && w_got) begin
                model_step(1'b1, got_addr, got_data);
                wr_landed = 1'b1;
                aw_got    = 1'b0;
                w_got     = 1'b0;
            end else begin
                model_step(1'b0, '0, '0);
            end
            if (ar_hs) ar_seen = 1'b1;
        end
        #1;
        if (aw_hs) awvalid = 1'b0;
        if (w_hs)  wvalid  = 1'b0;
        if (ar_hs) arvalid = 1'b0;
    endtask

    // lead > 0: AW leads W by lead cycles; lead < 0: W leads AW
    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int lead,
                             input int hold, output logic [1:0] resp);
        logic [1:0] eresp;
        eresp     = m_resp(a);
        wr_landed = 1'b0;
        awaddr    = a;
        wdata     = d;
        if (lead >= 0) awvalid = 1'b1;
        if (lead <= 0) wvalid  = 1'b1;
        repeat (lead < 0 ? -lead : lead) tick();
        if (lead > 0) wvalid  = 1'b1;
        if (lead < 0) awvalid = 1'b1;
        for (int n = 0; n < 20 && !wr_landed; n++) tick();
        check("wr_accept", 32'(wr_landed), 32'd1);
        if (!wr_landed) begin awvalid = 1'b0; wvalid = 1'b0; end
        check("bvalid", 32'(bvalid), 32'd1);
        check("bresp", 32'(bresp), 32'(eresp));
        resp = bresp;
        for (int n = 0; n < hold; n++) begin
            tick();
            check("bvalid_hold", 32'(bvalid), 32'd1);
            check("bresp_hold", 32'(bresp), 32'(eresp));
            check("aw_w_blocked", 32'({awready, wready}), 32'd0);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("bvalid_drop", 32'(bvalid), 32'd0);
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input int hold,
                            output logic [DW-1:0] d, output logic [1:0] resp);
        logic [DW-1:0] first;
        ar_seen = 1'b0;
        araddr  = a;
        arvalid = 1'b1;
        for (int n = 0; n < 20 && !ar_seen; n++) tick();
        check("ar_accept", 32'(ar_seen), 32'd1);
        if (!ar_seen) arvalid = 1'b0;
        check("rvalid", 32'(rvalid), 32'd1);
        first = rdata;
        for (int n = 0; n < hold; n++) begin
            tick();
            check("rvalid_hold", 32'(rvalid), 32'd1);
            check("rdata_hold", rdata, first);
            check("ar_blocked", 32'(arready), 32'd0);
        end
        check("rdata", rdata, exp_rdata);
        check("rresp", 32'(rresp), 32'(exp_rresp));
        d    = rdata;
        resp = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rvalid_drop", 32'(rvalid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        logic [1:0]    r;
        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        aw_got = 1'b0; w_got = 1'b0; wr_landed = 1'b0; ar_seen = 1'b0;
        got_addr = '0; got_data = '0; exp_rdata = '0; exp_rresp = '0;
        model_reset();

        // reset
        tick(); tick();
        check("rst_handshake", 32'({awready, wready, bvalid, arready, rvalid}), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_resp", 32'({bresp, rresp}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        tick();
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            for (int unsigned k = 0; k < 4; k++) begin
                axi_read(AW'(c * 16 + k * 4), 0, d, r);
                check("rst_reg", d, 32'd0);
            end
        end

        // AW three cycles before W
        axi_write(8'h18, 32'd5, 3, 0, r);
        check("cmp1_resp", 32'(r), 32'd0);
        axi_read(8'h18, 0, d, r);
        check("cmp1_readback", d, 32'd5);

        // ch0 wrapping up-counter with irq
        axi_write(8'h08, 32'd3, 0, 0, r);
        axi_write(8'h00, 32'hB, 0, 0, r);
        for (int i = 0; i < 10; i++) begin
            axi_read(8'h04, 0, d, r);
            check("ch0_irq", 32'(irq), 32'(m_irq()));
        end
        check("ch0_irq_set", 32'(irq[0]), 32'd1);
        axi_write(8'h0C, 32'd1, 0, 0, r);
        check("ch0_irq_after_w1c", 32'(irq), 32'(m_irq()));
        axi_write(8'h00, 32'h8, 0, 0, r);
        axi_write(8'h0C, 32'd1, 0, 0, r);
        check("ch0_irq_clear", 32'(irq[0]), 32'd0);

        // ch2 one-shot down-counter
        axi_write(8'h24, 32'd2, 0, 0, r);
        axi_write(8'h20, 32'h5, -2, 0, r);
        repeat (8) tick();
        axi_read(8'h20, 0, d, r);
        check("ch2_ctrl_en_clr", d, 32'h4);
        axi_read(8'h24, 0, d, r);
        check("ch2_value_held", d, 32'd0);
        axi_read(8'h2C, 0, d, r);
        check("ch2_match", d, 32'd1);

        // out-of-range channel
        axi_write(AW'(NUM_CH * 16 + 4), 32'hDEAD_BEEF, 0, 0, r);
        check("oor_bresp", 32'(r), 32'd2);
        axi_read(AW'(NUM_CH * 16 + 4), 0, d, r);
        check("oor_rdata", d, 32'd0);
        check("oor_rresp", 32'(r), 32'd2);
        for (int unsigned k = 0; k < NUM_CH * 4; k++) axi_read(AW'(k * 4), 0, d, r);

        // backpressure
        axi_read(8'h18, 10, d, r);
        axi_write(8'h34, 32'd7, 0, 10, r);
        axi_read(8'h34, 0, d, r);
        check("bp_readback", d, 32'd7);

        // randomized traffic
        for (int i = 0; i < 150; i++) begin
            int unsigned   op, ch, rg;
            logic [AW-1:0] a;
            logic [DW-1:0] v;
            op = $urandom_range(0, 4);
            ch = $urandom_range(0, NUM_CH);
            rg = $urandom_range(0, 3);
            a  = AW'(ch * 16 + rg * 4);
            if (rg == 0)                        v = DW'($urandom_range(0, 15));
            else if ($urandom_range(0, 7) == 0) v = $urandom;
            else                                v = DW'($urandom_range(0, 12));
            if (op <= 1)      axi_write(a, v, $urandom_range(0, 4) - 2, $urandom_range(0, 3), r);
            else if (op <= 3) axi_read(a, $urandom_range(0, 3), d, r);
            else              repeat ($urandom_range(1, 6)) tick();
            check("rand_irq", 32'(irq), 32'(m_irq()));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
